// File: rtl/rm_pkg.sv
// Shared constants for the ray job scheduler: camera bundle layout and FSM states.
package rm_pkg;

    localparam int unsigned CAM_W      = 27;
    localparam int unsigned CAM_FIELDS = 12;
    localparam int unsigned CAM_BITS   = CAM_W * CAM_FIELDS;

    // cam_in field offsets, eye_x at the LSBs
    localparam int unsigned EYE_X_OFF    = 0 * CAM_W;
    localparam int unsigned EYE_Y_OFF    = 1 * CAM_W;
    localparam int unsigned EYE_Z_OFF    = 2 * CAM_W;
    localparam int unsigned LOOK_1_1_OFF = 3 * CAM_W;
    localparam int unsigned LOOK_1_2_OFF = 4 * CAM_W;
    localparam int unsigned LOOK_1_3_OFF = 5 * CAM_W;
    localparam int unsigned LOOK_2_1_OFF = 6 * CAM_W;
    localparam int unsigned LOOK_2_2_OFF = 7 * CAM_W;
    localparam int unsigned LOOK_2_3_OFF = 8 * CAM_W;
    localparam int unsigned LOOK_3_1_OFF = 9 * CAM_W;
    localparam int unsigned LOOK_3_2_OFF = 10 * CAM_W;
    localparam int unsigned LOOK_3_3_OFF = 11 * CAM_W;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StDispatch = 2'd1,
        StDrain    = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [WIDTH-1:0] gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            idx = PTR_W'((32'(ptr_i) + i) % WIDTH);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ray_job_scheduler.sv
// Hands raster-order pixel jobs to raymarching cores and writes their results
// into the frame buffer.
module ray_job_scheduler
    import rm_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480,
    parameter int unsigned CORDW     = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic [CAM_BITS-1:0]       cam_in,
    output logic [CAM_BITS-1:0]       cam_out,
    output logic [NUM_CORES-1:0]      job_valid,
    input  logic [NUM_CORES-1:0]      job_ready,
    output logic [CORDW-1:0]          job_x,
    output logic [CORDW-1:0]          job_y,
    input  logic [NUM_CORES-1:0]      res_valid,
    output logic [NUM_CORES-1:0]      res_ready,
    input  logic [NUM_CORES*CORDW-1:0] res_x,
    input  logic [NUM_CORES*CORDW-1:0] res_y,
    input  logic [NUM_CORES*16-1:0]   res_color,
    output logic                      fb_we,
    output logic [18:0]               fb_addr,
    output logic [15:0]               fb_data,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned OUT_W = $clog2(NUM_CORES + 1);

    state_e              state_q, state_d;
    logic [CAM_BITS-1:0] cam_q, cam_d;
    logic [CORDW-1:0]    x_q, x_d, y_q, y_d;
    logic [PTR_W-1:0]    job_ptr_q, job_ptr_d, res_ptr_q, res_ptr_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                fb_we_q, fb_we_d;
    logic [18:0]         fb_addr_q, fb_addr_d;
    logic [15:0]         fb_data_q, fb_data_d;
    logic                done_q, done_d;

    logic [NUM_CORES-1:0] job_req, job_gnt, res_gnt;
    logic [PTR_W-1:0]     job_idx, res_idx;
    logic                 job_xfer, res_xfer, cnt_inc, cnt_dec;
    logic [CORDW-1:0]     sel_x, sel_y;
    logic [15:0]          sel_c;

    function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] i);
        if (32'(i) == NUM_CORES - 1) return '0;
        return i + 1'b1;
    endfunction

    assign job_req = (state_q == StDispatch) ? job_ready : '0;

    rr_arbiter #(
        .WIDTH (NUM_CORES),
        .PTR_W (PTR_W)
    ) u_job_arb (
        .req_i     (job_req),
        .ptr_i     (job_ptr_q),
        .gnt_o     (job_gnt),
        .gnt_idx_o (job_idx)
    );

    rr_arbiter #(
        .WIDTH (NUM_CORES),
        .PTR_W (PTR_W)
    ) u_res_arb (
        .req_i     (res_valid),
        .ptr_i     (res_ptr_q),
        .gnt_o     (res_gnt),
        .gnt_idx_o (res_idx)
    );

    assign job_xfer = |(job_gnt & job_ready);
    assign res_xfer = |(res_gnt & res_valid);
    assign sel_x    = res_x[res_idx*CORDW +: CORDW];
    assign sel_y    = res_y[res_idx*CORDW +: CORDW];
    assign sel_c    = res_color[res_idx*16 +: 16];

    // Results landing in IDLE belong to no frame and must not disturb the count
    assign cnt_inc = job_xfer;
    assign cnt_dec = res_xfer && (state_q != StIdle);

    always_comb begin
        state_d   = state_q;
        cam_d     = cam_q;
        x_d       = x_q;
        y_d       = y_q;
        job_ptr_d = job_ptr_q;
        res_ptr_d = res_ptr_q;
        out_d     = out_q;
        fb_we_d   = res_xfer;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        done_d    = 1'b0;

        if (res_xfer) begin
            res_ptr_d = next_ptr(res_idx);
            fb_addr_d = 19'(sel_y) * 19'(H_RES) + 19'(sel_x);
            fb_data_d = sel_c;
        end
        if (job_xfer) begin
            job_ptr_d = next_ptr(job_idx);
        end

        if (cnt_inc && !cnt_dec) begin
            out_d = out_q + 1'b1;
        end else if (cnt_dec && !cnt_inc && (out_q != '0)) begin
            out_d = out_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d = StDispatch;
                    cam_d   = cam_in;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            StDispatch: begin
                if (job_xfer) begin
                    if (x_q == CORDW'(H_RES - 1)) begin
                        x_d = '0;
                        if (y_q == CORDW'(V_RES - 1)) begin
                            y_d     = '0;
                            state_d = StDrain;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                // Done lines up with the fb_we of the last result
                if (out_d == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cam_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            job_ptr_q <= '0;
            res_ptr_q <= '0;
            out_q     <= '0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cam_q     <= cam_d;
            x_q       <= x_d;
            y_q       <= y_d;
            job_ptr_q <= job_ptr_d;
            res_ptr_q <= res_ptr_d;
            out_q     <= out_d;
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            done_q    <= done_d;
        end
    end

    assign cam_out    = cam_q;
    assign job_valid  = job_gnt;
    assign res_ready  = res_gnt;
    assign job_x      = x_q;
    assign job_y      = y_q;
    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = done_q;

endmodule

// File: tb/tb_ray_job_scheduler.sv
// Randomised bench for ray_job_scheduler against a frame-level reference model.
// Frame height is reduced so full frames stay short; the width stays at 640.
module tb_ray_job_scheduler;

    localparam int NC    = 4;
    localparam int H_RES = 640;
    localparam int V_RES = 8;
    localparam int CW    = 10;
    localparam int NPIX  = H_RES * V_RES;
    localparam int CAMB  = 324;

    logic            clk, reset, frame_start;
    logic [CAMB-1:0] cam_in, cam_out;
    logic [NC-1:0]   job_valid, job_ready, res_valid, res_ready;
    logic [CW-1:0]   job_x, job_y;
    logic [NC*CW-1:0] res_x, res_y;
    logic [NC*16-1:0] res_color;
    logic            fb_we, busy, frame_done;
    logic [18:0]     fb_addr;
    logic [15:0]     fb_data;

    ray_job_scheduler #(
        .NUM_CORES (NC),
        .H_RES     (H_RES),
        .V_RES     (V_RES),
        .CORDW     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .cam_in      (cam_in),
        .cam_out     (cam_out),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_x       (job_x),
        .job_y       (job_y),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_x       (res_x),
        .res_y       (res_y),
        .res_color   (res_color),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          core;
        int          x;
        int          y;
        logic [15:0] color;
        int          due;
    } res_t;

    // Core farm: every accepted job becomes a result after a delay
    res_t        pend[$];
    logic [NC-1:0] rdy_mask;
    bit          gate_busy, rnd_ready;
    int          dly_min, dly_max;
    int          cyc;

    // Frame-level reference: phase 0 idle, 1 dispatching, 2 draining
    int              m_phase, m_pix, m_out, m_jptr, m_rptr;
    logic [CAMB-1:0] m_cam;
    bit              exp_we, exp_done;
    int              exp_addr;
    logic [15:0]     exp_data;

    int job_log[$];
    int gnt_log[$];
    int hits[NPIX];
    int fb_cnt, done_cnt;
    int vec, errs;

    task automatic rand_cam();
        for (int k = 0; k < 10; k++) cam_in[k*32 +: 32] = $urandom;
        cam_in[323:320] = 4'($urandom);
    endtask

    task automatic model_clear();
        m_phase  = 0;
        m_pix    = 0;
        m_out    = 0;
        m_jptr   = 0;
        m_rptr   = 0;
        m_cam    = '0;
        exp_we   = 1'b0;
        exp_done = 1'b0;
        pend.delete();
    endtask

    task automatic clear_stats();
        foreach (hits[k]) hits[k] = 0;
        fb_cnt   = 0;
        done_cnt = 0;
        job_log.delete();
        gnt_log.delete();
    endtask

    task automatic drive_inputs();
        int first;
        for (int i = 0; i < NC; i++) begin
            first = -1;
            foreach (pend[k]) if (first < 0 && pend[k].core == i) first = k;
            res_valid[i]         = 1'b0;
            res_x[i*CW +: CW]    = '0;
            res_y[i*CW +: CW]    = '0;
            res_color[i*16 +: 16] = '0;
            if (first >= 0) begin
                if (pend[first].due <= cyc) begin
                    res_valid[i]          = 1'b1;
                    res_x[i*CW +: CW]     = CW'(pend[first].x);
                    res_y[i*CW +: CW]     = CW'(pend[first].y);
                    res_color[i*16 +: 16] = pend[first].color;
                end
            end
            job_ready[i] = rdy_mask[i] && !(gate_busy && first >= 0)
                           && (!rnd_ready || $urandom_range(1, 0) == 1);
        end
    endtask

    // One clock: drive at negedge, check and advance the model, return at next negedge
    task automatic cycle();
        int ej, er, c, sp, idx;
        logic [NC-1:0] ejv, erv;
        res_t e;
        drive_inputs();
        #1;
        vec++;
        if (fb_we !== exp_we) begin
            errs++;
            $display("FAIL fb_we cyc=%0d got=%b exp=%b", cyc, fb_we, exp_we);
        end
        if (exp_we) begin
            vec++;
            if (fb_addr !== 19'(exp_addr) || fb_data !== exp_data) begin
                errs++;
                $display("FAIL fb_write cyc=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                         cyc, fb_addr, fb_data, exp_addr, exp_data);
            end
        end
        if (fb_we === 1'b1) begin
            fb_cnt++;
            if (int'(fb_addr) < NPIX) hits[fb_addr]++;
        end
        vec++;
        if (frame_done !== exp_done) begin
            errs++;
            $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_done);
        end
        if (frame_done === 1'b1) done_cnt++;
        vec++;
        if (busy !== (m_phase != 0)) begin
            errs++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_phase != 0);
        end
        vec++;
        if (cam_out !== m_cam) begin
            errs++;
            $display("FAIL cam_out cyc=%0d got=%h exp=%h", cyc, cam_out, m_cam);
        end

        ej = -1;
        if (m_phase == 1)
            for (int k = 0; k < NC; k++) begin
                c = (m_jptr + k) % NC;
                if (ej < 0 && job_ready[c]) ej = c;
            end
        er = -1;
        for (int k = 0; k < NC; k++) begin
            c = (m_rptr + k) % NC;
            if (er < 0 && res_valid[c]) er = c;
        end
        ejv = '0;
        erv = '0;
        if (ej >= 0) ejv[ej] = 1'b1;
        if (er >= 0) erv[er] = 1'b1;
        vec++;
        if (job_valid !== ejv) begin
            errs++;
            $display("FAIL job_valid cyc=%0d got=%b exp=%b", cyc, job_valid, ejv);
        end
        vec++;
        if (res_ready !== erv) begin
            errs++;
            $display("FAIL res_ready cyc=%0d got=%b exp=%b", cyc, res_ready, erv);
        end

        sp       = m_phase;
        exp_we   = 1'b0;
        exp_done = 1'b0;
        if (ej >= 0) begin
            vec++;
            if (job_x !== CW'(m_pix % H_RES) || job_y !== CW'(m_pix / H_RES)) begin
                errs++;
                $display("FAIL job_xy cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", cyc, job_x, job_y,
                         m_pix % H_RES, m_pix / H_RES);
            end
            job_log.push_back(ej);
            e.core  = ej;
            e.x     = m_pix % H_RES;
            e.y     = m_pix / H_RES;
            e.color = 16'($urandom);
            e.due   = cyc + $urandom_range(dly_max, dly_min);
            pend.push_back(e);
            m_pix++;
            m_jptr = (ej + 1) % NC;
            m_out++;
            if (m_pix == NPIX) m_phase = 2;
        end
        if (er >= 0) begin
            idx = -1;
            foreach (pend[k]) if (idx < 0 && pend[k].core == er) idx = k;
            if (idx >= 0) begin
                e = pend[idx];
                pend.delete(idx);
                exp_we   = 1'b1;
                exp_addr = e.y * H_RES + e.x;
                exp_data = e.color;
            end
            gnt_log.push_back(er);
            m_rptr = (er + 1) % NC;
            if (sp != 0 && m_out > 0) m_out--;
        end
        if (sp == 2 && m_out == 0) begin
            m_phase  = 0;
            exp_done = 1'b1;
        end
        if (sp == 0 && frame_start) begin
            m_phase = 1;
            m_pix   = 0;
            m_cam   = cam_in;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to_idle(input int budget);
        int n;
        n = 0;
        while ((m_phase != 0 || exp_we || exp_done) && n < budget) begin
            cycle();
            n++;
        end
        vec++;
        if (n >= budget) begin
            errs++;
            $display("FAIL frame_timeout cyc=%0d phase=%0d pix=%0d", cyc, m_phase, m_pix);
        end
    endtask

    task automatic check_frame(input string tag);
        int bad;
        bad = 0;
        foreach (hits[k]) if (hits[k] != 1) bad++;
        vec++;
        if (fb_cnt != NPIX) begin
            errs++;
            $display("FAIL %s fb_count got=%0d exp=%0d", tag, fb_cnt, NPIX);
        end
        vec++;
        if (bad != 0) begin
            errs++;
            $display("FAIL %s addr_once got=%0d bad addresses exp=0", tag, bad);
        end
        vec++;
        if (done_cnt != 1) begin
            errs++;
            $display("FAIL %s frame_done_count got=%0d exp=1", tag, done_cnt);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_clear();
        drive_inputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        frame_start = 1'b1;
        rand_cam();
        for (int i = 0; i < 3; i++) begin
            #1;
            vec++;
            if ({job_valid, res_ready} !== '0) begin
                errs++;
                $display("FAIL rst_handshake got=%b exp=0", {job_valid, res_ready});
            end
            vec++;
            if ({job_x, job_y} !== '0) begin
                errs++;
                $display("FAIL rst_job_xy got=%h exp=0", {job_x, job_y});
            end
            vec++;
            if (cam_out !== '0) begin
                errs++;
                $display("FAIL rst_cam_out got=%h exp=0", cam_out);
            end
            vec++;
            if ({fb_we, fb_addr, fb_data} !== '0) begin
                errs++;
                $display("FAIL rst_fb got=%h exp=0", {fb_we, fb_addr, fb_data});
            end
            vec++;
            if ({busy, frame_done} !== 2'b00) begin
                errs++;
                $display("FAIL rst_status got=%b exp=00", {busy, frame_done});
            end
            @(negedge clk);
        end
        reset       = 1'b1;
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
    endtask

    task automatic test_full_frame();
        rdy_mask  = '1;
        gate_busy = 1'b0;
        rnd_ready = 1'b0;
        dly_min   = 1;
        dly_max   = 1;
        clear_stats();
        rand_cam();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        run_to_idle(4 * NPIX);
        check_frame("full_frame");
    endtask

    task automatic test_fairness();
        int exp_j[4] = '{1, 3, 1, 3};
        pulse_reset();
        rdy_mask  = 4'b1010;
        gate_busy = 1'b0;
        rnd_ready = 1'b0;
        dly_min   = 50;
        dly_max   = 50;
        clear_stats();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        for (int i = 0; i < 4; i++) begin
            vec++;
            if (job_log.size() <= i || job_log[i] != exp_j[i]) begin
                errs++;
                $display("FAIL job_fairness idx=%0d got=%0d exp=%0d", i,
                         (job_log.size() > i) ? job_log[i] : -1, exp_j[i]);
            end
        end
        // Results landing in IDLE are still written
        pulse_reset();
        rdy_mask = '0;
        clear_stats();
        for (int i = 0; i < NC; i++) begin
            res_t e;
            e.core  = i;
            e.x     = $urandom_range(H_RES - 1, 0);
            e.y     = $urandom_range(V_RES - 1, 0);
            e.color = 16'($urandom);
            e.due   = cyc;
            pend.push_back(e);
        end
        for (int i = 0; i < 6; i++) cycle();
        for (int i = 0; i < 4; i++) begin
            vec++;
            if (gnt_log.size() <= i || gnt_log[i] != i) begin
                errs++;
                $display("FAIL res_fairness idx=%0d got=%0d exp=%0d", i,
                         (gnt_log.size() > i) ? gnt_log[i] : -1, i);
            end
        end
    endtask

    task automatic test_address();
        res_t e;
        e.core  = 2;
        e.x     = 639;
        e.y     = 479;
        e.color = 16'hF800;
        e.due   = cyc;
        pend.push_back(e);
        cycle();
        #1;
        vec++;
        if (fb_we !== 1'b1 || fb_addr !== 19'd307199 || fb_data !== 16'hF800) begin
            errs++;
            $display("FAIL addr_arith got we=%b addr=%0d data=%h exp we=1 addr=307199 data=f800",
                     fb_we, fb_addr, fb_data);
        end
        cycle();
    endtask

    task automatic test_frame_start_busy();
        logic [CAMB-1:0] held;
        rdy_mask  = '1;
        gate_busy = 1'b0;
        rnd_ready = 1'b0;
        dly_min   = 1;
        dly_max   = 2;
        clear_stats();
        rand_cam();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        held = cam_in;
        for (int i = 0; i < 20; i++) cycle();
        rand_cam();
        frame_start = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        frame_start = 1'b0;
        vec++;
        if (cam_out !== held) begin
            errs++;
            $display("FAIL cam_hold_busy got=%h exp=%h", cam_out, held);
        end
        run_to_idle(4 * NPIX);
        check_frame("busy_start");
    endtask

    task automatic test_reset_mid_frame();
        int n;
        rdy_mask  = '1;
        gate_busy = 1'b0;
        rnd_ready = 1'b0;
        dly_min   = 1;
        dly_max   = 1;
        rand_cam();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        n = 0;
        while (m_pix < 1000 && n < 4000) begin
            cycle();
            n++;
        end
        #2;
        reset = 1'b0;
        model_clear();
        drive_inputs();
        #1;
        vec++;
        if (busy !== 1'b0 || job_valid !== '0 || fb_we !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset got busy=%b job_valid=%b fb_we=%b exp 0/0/0",
                     busy, job_valid, fb_we);
        end
        @(negedge clk);
        reset = 1'b1;
        clear_stats();
        for (int i = 0; i < 4; i++) cycle();
        rnd_ready = 1'b1;
        gate_busy = 1'b1;
        dly_min   = 1;
        dly_max   = 6;
        rand_cam();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        drive_inputs();
        #1;
        vec++;
        if (job_x !== '0 || job_y !== '0) begin
            errs++;
            $display("FAIL restart_origin got=(%0d,%0d) exp=(0,0)", job_x, job_y);
        end
        run_to_idle(8 * NPIX);
        check_frame("after_reset");
    endtask

    task automatic test_random();
        int n;
        rnd_ready = 1'b1;
        gate_busy = 1'b1;
        dly_min   = 1;
        dly_max   = 4;
        clear_stats();
        rand_cam();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        n = 0;
        while ((m_phase != 0 || exp_we || exp_done) && n < 8 * NPIX) begin
            rdy_mask    = 4'($urandom);
            frame_start = ($urandom_range(15, 0) == 0);
            if (frame_start) rand_cam();
            cycle();
            n++;
        end
        frame_start = 1'b0;
        vec++;
        if (n >= 8 * NPIX) begin
            errs++;
            $display("FAIL random_timeout cyc=%0d phase=%0d", cyc, m_phase);
        end
        check_frame("random");
    endtask

    initial begin
        vec         = 0;
        errs        = 0;
        cyc         = 0;
        reset       = 1'b0;
        frame_start = 1'b0;
        cam_in      = '0;
        rdy_mask    = '0;
        gate_busy   = 1'b0;
        rnd_ready   = 1'b0;
        dly_min     = 1;
        dly_max     = 1;
        model_clear();
        clear_stats();
        drive_inputs();
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_fairness();
        test_address();
        test_frame_start_busy();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/ray_job_scheduler.md
RAY_JOB_SCHEDULER -- requirements
Module: ray_job_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, giving the number of raymarching cores served.
REQ-002 SHALL have parameter H_RES, default 640, giving the frame width in pixels.
REQ-003 SHALL have parameter V_RES, default 480, giving the frame height in pixels.
REQ-004 SHALL have parameter CORDW, default 10, giving the coordinate width.
REQ-005 SHALL have the port clk, input, 1 bit, the sole clock.
REQ-006 SHALL have the port reset, input, 1 bit, asynchronous and active-low.
REQ-007 SHALL have the port frame_start, input, 1 bit, a pulse requesting a new frame.
REQ-008 SHALL have the port cam_in, input, 324 bits: eye_x/y/z then look_at_1_1..3_3, 27 bits each, eye_x at the LSBs.
REQ-009 SHALL have the port cam_out, output, 324 bits, the camera parameters latched for the current frame.
REQ-010 SHALL have the port job_valid, output, NUM_CORES bits, one-hot job offer.
REQ-011 SHALL have the port job_ready, input, NUM_CORES bits, core idle.
REQ-012 SHALL have the ports job_x and job_y, outputs, CORDW bits each, the pixel coordinate broadcast to all cores.
REQ-013 SHALL have the port res_valid, input, NUM_CORES bits, a result pending per core.
REQ-014 SHALL have the port res_ready, output, NUM_CORES bits, one-hot result accept.
REQ-015 SHALL have the port res_x, input, NUM_CORES*CORDW bits, with core 0 at the LSBs.
REQ-016 SHALL have the port res_y, input, NUM_CORES*CORDW bits, with core 0 at the LSBs.
REQ-017 SHALL have the port res_color, input, NUM_CORES*16 bits, RGB565 with core 0 at the LSBs.
REQ-018 SHALL have the port fb_we, output, 1 bit, the frame-buffer write strobe.
REQ-019 SHALL have the port fb_addr, output, 19 bits, the frame-buffer address.
REQ-020 SHALL have the port fb_data, output, 16 bits, the frame-buffer write data.
REQ-021 SHALL have the port busy, output, 1 bit, high when not IDLE.
REQ-022 SHALL have the port frame_done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-023 SHALL implement the FSM IDLE->DISPATCH (frame_start)->DRAIN (last pixel dispatched)->IDLE (outstanding==0, with a frame_done pulse).
REQ-024 SHALL latch cam_in into cam_out only on frame_start in IDLE; frame_start outside IDLE is ignored and cam_out holds.
REQ-025 SHALL dispatch pixels in raster order starting at (0,0): x increments to H_RES-1, then wraps to 0 and y increments; the pixel after (H_RES-1,V_RES-1) ends DISPATCH.
REQ-026 SHALL, in DISPATCH, set job_valid to the first set job_ready bit searched from job_ptr upward with wrap; job_valid is all-zero when no core is ready or outside DISPATCH.
REQ-027 SHALL treat a job as transferred when job_valid[i]&job_ready[i]; on transfer the coordinate advances and job_ptr becomes i+1 mod NUM_CORES; at most 1 job per cycle.
REQ-028 SHALL make res_ready a round-robin one-hot grant over res_valid from res_ptr, active in any state; on grant res_ptr becomes i+1 mod NUM_CORES; at most 1 result per cycle.
REQ-029 SHALL, on a granted result, drive fb_we=1, fb_addr=res_y*H_RES+res_x and fb_data=res_color on the next cycle (registered, latency 1).
REQ-030 SHALL keep an outstanding counter (width clog2(NUM_CORES+1)) that is +1 per dispatch and -1 per result; a simultaneous dispatch and result leaves it unchanged.
REQ-031 SHALL raise frame_done when the final fb_we is issued, not before.
REQ-032 SHALL ignore a result arriving in IDLE for counting, but still write it and never underflow the counter (saturate at 0).

Reset
REQ-033 SHALL, on reset low, asynchronously go to IDLE and clear job_x/job_y, job_ptr, res_ptr, outstanding, cam_out, fb_we, fb_addr, fb_data, busy and frame_done to 0.
REQ-034 SHALL abandon a frame on reset mid-frame, restart only on a new frame_start, and issue no fb_we until a result is granted after release.

Structure
REQ-035 SHALL place the CAM_W=27 constant, the cam_in field offsets and the state enum in shared package rm_pkg.
REQ-036 SHALL implement both round-robin grants with one sub-module, rr_arbiter (parameterised width, req/ptr in, one-hot grant out), instantiated twice.

Verification
REQ-037 SHALL verify reset: with reset=0 all outputs are 0 and busy=0; frame_start during reset has no effect.
REQ-038 SHALL verify full-frame dispatch: NUM_CORES=4, all cores always ready, 1-cycle result turnaround -> exactly 307200 fb_we, each address 0..307199 once, frame_done once.
REQ-039 SHALL verify fairness: only cores 1 and 3 ready -> jobs alternate 1,3,1,3; four simultaneous res_valid -> grants in order 0,1,2,3.
REQ-040 SHALL verify address arithmetic: a result (x=639,y=479,color=16'hF800) -> fb_addr=307199 and fb_data=F800 one cycle after grant.
REQ-041 SHALL verify a frame_start while busy is ignored: cam_in changes mid-frame and cam_out is unchanged.
REQ-042 SHALL verify reset mid-frame: reset at pixel 1000 -> IDLE, outstanding=0, and the next frame starts at (0,0).
